// File: rtl/core_scheduler.sv
// Block-level instruction sequencer: steps every thread lane in lockstep through
// FETCH, DECODE, REQUEST, WAIT, EXECUTE and UPDATE, then retires the instruction.
module core_scheduler #(
  parameter int unsigned THREADS_PER_BLOCK = 4,
  parameter int unsigned PC_BITS           = 8,
  parameter logic [15:0] INSTR_COUNT_MAX   = 16'hFFFF
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [2:0]                             fetcher_state,
  input  logic                                   decoded_ret,
  input  logic                                   decoded_mem_read_enable,
  input  logic                                   decoded_mem_write_enable,
  input  logic                                   decoded_tensor_enable,
  input  logic                                   tensor_done,
  input  logic [2*THREADS_PER_BLOCK-1:0]         lsu_state,
  input  logic [PC_BITS*THREADS_PER_BLOCK-1:0]   next_pc,
  output logic [2:0]                             core_state,
  output logic [PC_BITS-1:0]                     current_pc,
  output logic                                   done,
  output logic [15:0]                            instr_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } state_e;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;

  state_e               state_q;
  logic [PC_BITS-1:0]   pc_q;
  logic                 done_q;
  logic [15:0]          count_q;
  logic [15:0]          count_d;
  logic [PC_BITS-1:0]   branch_pc;
  logic                 lsu_busy;
  logic                 stall;
  logic                 unused_inputs;

  // Memory enables are informational only: stalls come straight from lsu_state.
  assign unused_inputs = ^{decoded_mem_read_enable, decoded_mem_write_enable, next_pc};

  // A lane is in flight (REQUESTING/WAITING) exactly when its two state bits differ.
  always_comb begin
    lsu_busy = 1'b0;
    for (int unsigned i = 0; i < THREADS_PER_BLOCK; i++) begin
      if (lsu_state[2*i] ^ lsu_state[2*i+1]) lsu_busy = 1'b1;
    end
  end

  assign stall     = lsu_busy || (decoded_tensor_enable && !tensor_done);
  assign branch_pc = next_pc[PC_BITS*THREADS_PER_BLOCK-1 -: PC_BITS];

  always_comb begin
    count_d = count_q;
    if (count_q < INSTR_COUNT_MAX) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            done_q  <= 1'b0;
            count_q <= '0;
          end
        end
        S_FETCH:   if (fetcher_state == FETCHER_FETCHED) state_q <= S_DECODE;
        S_DECODE:  state_q <= S_REQUEST;
        S_REQUEST: state_q <= S_WAIT;
        S_WAIT:    if (!stall) state_q <= S_EXECUTE;
        S_EXECUTE: state_q <= S_UPDATE;
        S_UPDATE: begin
          count_q <= count_d;
          if (decoded_ret) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_FETCH;
            pc_q    <= branch_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_state  = state_q;
  assign current_pc  = pc_q;
  assign done        = done_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler: scripted instructions with literal expectations,
// plus a rule-level reference model compared against the outputs after every clock edge.
module tb_core_scheduler;

  localparam int          T    = 4;
  localparam int          PCB  = 8;
  localparam logic [15:0] CMAX = 16'd24;

  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, REQUEST = 3'd3,
                         WAIT = 3'd4, EXECUTE = 3'd5, UPDATE = 3'd6, DONE = 3'd7;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [2:0]        fetcher_state = 3'b000;
  logic              decoded_ret = 1'b0;
  logic              mem_rd = 1'b0;
  logic              mem_wr = 1'b0;
  logic              tensor_en = 1'b0;
  logic              tensor_done = 1'b0;
  logic [2*T-1:0]    lsu_state = '0;
  logic [PCB*T-1:0]  next_pc = '0;
  logic [2:0]        core_state;
  logic [PCB-1:0]    current_pc;
  logic              done;
  logic [15:0]       instr_count;

  int errors = 0;
  int checks = 0;

  core_scheduler #(
    .THREADS_PER_BLOCK(T),
    .PC_BITS(PCB),
    .INSTR_COUNT_MAX(CMAX)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .start                    (start),
    .fetcher_state            (fetcher_state),
    .decoded_ret              (decoded_ret),
    .decoded_mem_read_enable  (mem_rd),
    .decoded_mem_write_enable (mem_wr),
    .decoded_tensor_enable    (tensor_en),
    .tensor_done              (tensor_done),
    .lsu_state                (lsu_state),
    .next_pc                  (next_pc),
    .core_state               (core_state),
    .current_pc               (current_pc),
    .done                     (done),
    .instr_count              (instr_count)
  );

  always #5 clk = ~clk;

  // Reference model: expected outputs derived from the stage rules.
  logic [2:0]     m_state;
  logic [PCB-1:0] m_pc;
  logic           m_done;
  logic [15:0]    m_cnt;

  function automatic bit lanes_busy(input logic [2*T-1:0] l);
    for (int i = 0; i < T; i++) begin
      int v;
      v = int'(l[2*i +: 2]);
      if (v == 1 || v == 2) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state <= IDLE; m_pc <= '0; m_done <= 1'b0; m_cnt <= '0;
    end else begin
      case (m_state)
        IDLE: if (start) begin
          m_state <= FETCH; m_pc <= '0; m_done <= 1'b0; m_cnt <= '0;
        end
        FETCH: if (fetcher_state == 3'b010) m_state <= DECODE;
        DECODE, REQUEST, EXECUTE: m_state <= m_state + 3'd1;
        WAIT: if (!(lanes_busy(lsu_state) || (tensor_en && !tensor_done))) m_state <= EXECUTE;
        UPDATE: begin
          m_cnt <= (m_cnt >= CMAX) ? m_cnt : m_cnt + 16'd1;
          if (decoded_ret) begin
            m_state <= DONE; m_done <= 1'b1;
          end else begin
            m_state <= FETCH; m_pc <= next_pc[PCB*T-1 -: PCB];
          end
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("model_state", {13'd0, core_state}, {13'd0, m_state});
    chk("model_pc",    {8'd0, current_pc},  {8'd0, m_pc});
    chk("model_done",  {15'd0, done},       {15'd0, m_done});
    chk("model_count", instr_count,         m_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  task automatic st(input string name, input logic [2:0] exp);
    chk(name, {13'd0, core_state}, {13'd0, exp});
  endtask

  initial begin
    logic [2:0] seq1 [6];
    seq1 = '{DECODE, REQUEST, WAIT, EXECUTE, UPDATE, FETCH};

    #1 reset = 1'b0;
    repeat (3) tick();
    st("reset_state", IDLE);
    chk("reset_pc", {8'd0, current_pc}, 16'd0);
    chk("reset_done", {15'd0, done}, 16'd0);
    chk("reset_count", instr_count, 16'd0);
    reset = 1'b1;
    repeat (2) tick();
    st("idle_hold", IDLE);

    // Straight-line instruction, all lanes branch to 1.
    fetcher_state = 3'b010;
    next_pc = {T{8'h01}};
    start = 1'b1;
    tick(); start = 1'b0;
    st("t1_fetch", FETCH);
    for (int i = 0; i < 6; i++) begin
      tick();
      st("t1_seq", seq1[i]);
    end
    chk("t1_pc", {8'd0, current_pc}, 16'h0001);
    chk("t1_count", instr_count, 16'd1);

    // LDR: lane 2 REQUESTING then WAITING; other lanes idle/done never stall.
    mem_rd = 1'b1;
    next_pc = {T{8'h02}};
    lsu_state = {2'b11, 2'b00, 2'b00, 2'b11};
    tick(); st("t2_decode", DECODE);
    tick(); st("t2_request", REQUEST); lsu_state[5:4] = 2'b01;
    tick(); st("t2_wait1", WAIT);
    tick(); st("t2_wait2", WAIT); lsu_state[5:4] = 2'b10;
    tick(); st("t2_wait3", WAIT);
    tick(); st("t2_wait4", WAIT);
    tick(); st("t2_wait5", WAIT); lsu_state[5:4] = 2'b11;
    tick(); st("t2_execute", EXECUTE);
    tick(); st("t2_update", UPDATE); mem_rd = 1'b0; lsu_state = '0;
    tick(); st("t2_fetch", FETCH);
    chk("t2_pc", {8'd0, current_pc}, 16'h0002);
    chk("t2_count", instr_count, 16'd2);

    // GEMM with a slow fetch; stray start/ret in non-sampling states are ignored.
    fetcher_state = 3'b001;
    start = 1'b1;
    tensor_en = 1'b1;
    next_pc = {8'd9, 8'd7, 8'd5, 8'd3};
    repeat (3) begin tick(); st("t3_fetch_hold", FETCH); end
    fetcher_state = 3'b010; start = 1'b0;
    tick(); st("t3_decode", DECODE);
    tick(); st("t3_request", REQUEST);
    tick(); st("t3_wait1", WAIT);
    tick(); st("t3_wait2", WAIT); decoded_ret = 1'b1;
    tick(); st("t3_wait3", WAIT);
    tick(); st("t3_wait4", WAIT); tensor_done = 1'b1;
    tick(); st("t3_execute", EXECUTE);
    tensor_en = 1'b0; tensor_done = 1'b0; decoded_ret = 1'b0;
    tick(); st("t3_update", UPDATE);
    tick(); st("t3_fetch", FETCH);
    chk("t3_pc_last_lane", {8'd0, current_pc}, 16'h0009);
    chk("t3_count", instr_count, 16'd3);

    // RET: terminal DONE, pc untouched, later start ignored.
    decoded_ret = 1'b1;
    next_pc = {T{8'hAA}};
    repeat (5) tick();
    st("t4_update", UPDATE);
    tick(); st("t4_done", DONE);
    chk("t4_done_flag", {15'd0, done}, 16'd1);
    chk("t4_pc_kept", {8'd0, current_pc}, 16'h0009);
    chk("t4_count", instr_count, 16'd4);
    start = 1'b1;
    repeat (3) tick();
    st("t4_done_hold", DONE);
    chk("t4_pc_hold", {8'd0, current_pc}, 16'h0009);
    chk("t4_count_hold", instr_count, 16'd4);
    start = 1'b0; decoded_ret = 1'b0;

    // Asynchronous reset in the middle of a stalled WAIT.
    reset = 1'b0; tick(); reset = 1'b1; tick();
    st("t5_idle_after_reset", IDLE);
    next_pc = {T{8'h01}};
    lsu_state = {2'b00, 2'b00, 2'b00, 2'b01};
    start = 1'b1;
    tick(); start = 1'b0;
    repeat (4) tick();
    st("t5_in_wait", WAIT);
    #2 reset = 1'b0;
    #1;
    st("t5_async_state", IDLE);
    chk("t5_async_pc", {8'd0, current_pc}, 16'd0);
    chk("t5_async_done", {15'd0, done}, 16'd0);
    chk("t5_async_count", instr_count, 16'd0);
    cmp_model();
    tick();
    reset = 1'b1; lsu_state = '0;
    repeat (3) tick();
    st("t5_idle_until_start", IDLE);

    // Long run of plain instructions drives the counter into saturation.
    next_pc = {T{8'h10}};
    start = 1'b1;
    tick(); start = 1'b0;
    repeat (30 * 6) tick();
    chk("t6_count_saturated", instr_count, CMAX);
    chk("t6_pc", {8'd0, current_pc}, 16'h0010);
    st("t6_state", FETCH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_scheduler.md
CORE_SCHEDULER -- requirements
Module: core_scheduler

Interface
REQ-001 The block SHALL have parameter THREADS_PER_BLOCK, default 4, the number of thread lanes sequenced in lockstep.
REQ-002 The block SHALL have parameter PC_BITS, default 8, the program-counter width.
REQ-003 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  begin block execution; sampled only in IDLE.
REQ-006 Port: fetcher_state  input  3  instruction fetcher state; 3'b010 = FETCHED.
REQ-007 Port: decoded_ret  input  1  the current instruction is RET.
REQ-008 Port: decoded_mem_read_enable / decoded_mem_write_enable  input  1 each  the current instruction is LDR / STR.
REQ-009 Port: decoded_tensor_enable  input  1  the current instruction is GEMM.
REQ-010 Port: tensor_done  input  1  the GEMM unit result is valid.
REQ-011 Port: lsu_state  input  2*THREADS_PER_BLOCK  per-thread LSU state (thread i at bits [2i+1:2i]); 00 IDLE, 01 REQUESTING, 10 WAITING, 11 DONE.
REQ-012 Port: next_pc  input  PC_BITS*THREADS_PER_BLOCK  per-thread PC-unit result (thread i at bits [PC_BITS*(i+1)-1:PC_BITS*i]).
REQ-013 Port: core_state  output  3  state broadcast to the fetcher, decoder, register files, ALUs, LSUs and PC units.
REQ-014 Port: current_pc  output  PC_BITS  shared program counter.
REQ-015 Port: done  output  1  the block has retired RET.
REQ-016 Port: instr_count  output  16  count of retired instructions.

Function
REQ-017 core_state encoding SHALL be: IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111. Register files sample rs/rt in REQUEST and write rd in UPDATE.
REQ-018 IDLE: start=1 -> FETCH next cycle, with current_pc<=0, instr_count<=0, done<=0. start=0 -> remain in IDLE.
REQ-019 FETCH: fetcher_state==010 -> DECODE. Otherwise remain in FETCH (no timeout).
REQ-020 DECODE SHALL go unconditionally to REQUEST, and REQUEST unconditionally to WAIT (one cycle each).
REQ-021 WAIT SHALL be held while any thread's lsu_state is 01 or 10, or while decoded_tensor_enable=1 and tensor_done=0. Otherwise WAIT -> EXECUTE.
REQ-022 Lanes whose lsu_state is 00 or 11 SHALL never stall WAIT. Minimum WAIT dwell is 1 cycle.
REQ-023 EXECUTE SHALL go unconditionally to UPDATE.
REQ-024 UPDATE with decoded_ret=1 SHALL go to DONE, set done<=1, and leave current_pc unchanged.
REQ-025 UPDATE with decoded_ret=0 SHALL go to FETCH with current_pc<=next_pc of thread THREADS_PER_BLOCK-1 (convergent-branch rule; divergence is not handled).
REQ-026 Every UPDATE cycle, including RET, SHALL increment instr_count by 1, saturating at 16'hFFFF.
REQ-027 DONE SHALL be terminal until reset. start is ignored; outputs are held.
REQ-028 current_pc SHALL change only in IDLE->FETCH and in UPDATE. Values wider than PC_BITS are impossible by construction.
REQ-029 Minimum instruction latency SHALL be 6 cycles (FETCH..UPDATE) when fetcher_state is FETCHED on the first FETCH cycle and no stall occurs.
REQ-030 Input values in states that do not sample them SHALL have no effect.

Reset
REQ-031 reset=0 SHALL immediately, without waiting for clk, force core_state=IDLE, current_pc=0, done=0, instr_count=0, from any state including mid-WAIT.
REQ-032 After reset deasserts, the block SHALL remain in IDLE until start=1 is sampled on a rising edge.

Verification
REQ-033 Reset, then start=1 for 1 cycle, fetcher FETCHED immediately, no mem/tensor, decoded_ret=0, all next_pc=8'h01 -> state sequence 001,010,011,100,101,110,001; current_pc=1, instr_count=1.
REQ-034 LDR with thread 2 lsu_state 01 for 2 cycles, then 10 for 3 cycles, then 11 -> WAIT held exactly 5 cycles, then EXECUTE.
REQ-035 GEMM with tensor_done rising 4 cycles after WAIT entry -> EXECUTE on the cycle after tensor_done=1 is sampled.
REQ-036 decoded_ret=1 in UPDATE -> DONE, done=1, current_pc unchanged. A later start=1 has no effect.
REQ-037 reset=0 asserted mid-clock while in WAIT -> all outputs zero and state IDLE before the next clk edge.
REQ-038 Next_pc per thread {3,5,7,9} -> current_pc=9 after UPDATE. Preload instr_count to 16'hFFFF (via a 65535-instruction loop) -> the count stays 16'hFFFF.
